// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller: drives the CPU clock enable from free-run and single-step requests.
// It stops on a PC breakpoint or a cycle limit, and counts the enabled cycles.
module cpu_run_ctrl #(
  parameter int CNT_W = 32,
  parameter int PC_W  = 32
) (
  input  logic             CLK_CPU,
  input  logic             RST_CPU,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             clr,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic [CNT_W-1:0] limit,
  output logic             cpu_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [1:0]       state,
  output logic [1:0]       halt_cause
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_BP    = 2'd1;
  localparam logic [1:0] CAUSE_LIMIT = 2'd2;

  state_e           state_q;
  logic [1:0]       cause_q;
  logic             bp_skip_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic run_meta_q, run_s_q, run_prev_q;
  logic step_meta_q, step_s_q, step_prev_q;

  logic run_p;
  logic step_p;
  logic lim_hit;
  logic bp_hit;

  assign run_p   = run_s_q & ~run_prev_q;
  assign step_p  = step_s_q & ~step_prev_q;
  assign lim_hit = (limit != '0) && (cnt_q >= limit);
  assign bp_hit  = bp_en && (pc == bp_addr) && !bp_skip_q;

  // Breakpoints are ignored while stepping so the CPU can step off one.
  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      ST_RUN:  cpu_en = !lim_hit && !bp_hit;
      ST_STEP: cpu_en = !lim_hit;
      default: cpu_en = 1'b0;
    endcase
  end

  // clr wins over counting, even in a cycle where cpu_en is still high.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (cpu_en && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK_CPU or posedge RST_CPU) begin
    if (RST_CPU) begin
      run_meta_q  <= 1'b0;
      run_s_q     <= 1'b0;
      run_prev_q  <= 1'b0;
      step_meta_q <= 1'b0;
      step_s_q    <= 1'b0;
      step_prev_q <= 1'b0;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      cause_q     <= CAUSE_NONE;
      bp_skip_q   <= 1'b0;
    end else begin
      run_meta_q  <= run_req;
      run_s_q     <= run_meta_q;
      run_prev_q  <= run_s_q;
      step_meta_q <= step_req;
      step_s_q    <= step_meta_q;
      step_prev_q <= step_s_q;
      cnt_q       <= cnt_d;

      if (clr) begin
        state_q   <= ST_IDLE;
        cause_q   <= CAUSE_NONE;
        bp_skip_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (run_s_q)
              state_q <= ST_RUN;
            else if (step_p)
              state_q <= ST_STEP;
          end
          ST_RUN: begin
            bp_skip_q <= 1'b0;
            if (lim_hit) begin
              state_q <= ST_HALT;
              cause_q <= CAUSE_LIMIT;
            end else if (bp_hit) begin
              state_q <= ST_HALT;
              cause_q <= CAUSE_BP;
            end else if (!run_s_q) begin
              state_q <= ST_IDLE;
            end
          end
          ST_STEP: begin
            if (lim_hit) begin
              state_q <= ST_HALT;
              cause_q <= CAUSE_LIMIT;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_HALT: begin
            // Resume needs a fresh run edge; the skip lets the halted instruction execute.
            if (run_p) begin
              state_q   <= ST_RUN;
              bp_skip_q <= 1'b1;
              cause_q   <= CAUSE_NONE;
            end else if (step_p) begin
              state_q <= ST_STEP;
              cause_q <= CAUSE_NONE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign cycle_cnt  = cnt_q;
  assign state      = state_q;
  assign halt_cause = cause_q;

endmodule
